// File: rtl/lcd_glyph_if.sv
// lcd_glyph_if: host-side glyph request handshake into the LCD writer
interface lcd_glyph_if;
    logic         start;
    logic [255:0] mark;
    logic [2:0]   slot;
    logic [1:0]   line;
    logic         ready;
    logic         done;
    modport master (output start, mark, slot, line, input ready, done);
    modport slave  (input start, mark, slot, line, output ready, done);
endinterface

// File: rtl/lcd_glyph_writer.sv
// lcd_glyph_writer: powers up a KS0108 dual-controller panel, then writes one 16x16 glyph per start/done handshake
module lcd_glyph_writer #(
    parameter int EN_HIGH = 2,
    parameter int EN_LOW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    lcd_glyph_if.slave  host,
    output logic [1:0]  lcd_cs,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic [7:0]  lcd_data
);
    localparam int W  = 1 + EN_HIGH + EN_LOW;
    localparam int TW = $clog2(W);
    typedef enum logic [2:0] {INIT_ON, INIT_LINE, IDLE, PAGE, YADDR, DATA, FIN} state_t;
    state_t state, state_n;
    logic          run;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    col, col_n;
    logic          half, half_n;
    logic [255:0]  m;
    logic [2:0]    s;
    logic [1:0]    l;
    logic          busy, last, accept;
    logic [7:0]    pix;
    // run holds everything at reset values for the first edge after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            state <= INIT_ON;
            tcnt  <= '0;
            col   <= '0;
            half  <= 1'b0;
            m     <= '0;
            s     <= '0;
            l     <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                state <= state_n;
                tcnt  <= tcnt_n;
                col   <= col_n;
                half  <= half_n;
            end
            if (accept) begin
                m <= host.mark;
                s <= host.slot;
                l <= host.line;
            end
        end
    end
    always_comb begin
        busy    = run && state != IDLE && state != FIN;
        last    = tcnt == TW'(W - 1);
        accept  = run && state == IDLE && host.start;
        state_n = state;
        tcnt_n  = (busy && !last) ? tcnt + 1'b1 : '0;
        col_n   = col;
        half_n  = half;
        if (accept) begin
            state_n = PAGE;
            col_n   = '0;
            half_n  = 1'b0;
        end else if (state == FIN) begin
            state_n = IDLE;
        end else if (busy && last) begin
            case (state)
                INIT_ON:   state_n = INIT_LINE;
                INIT_LINE: state_n = IDLE;
                PAGE:      state_n = YADDR;
                YADDR:     state_n = DATA;
                default: begin
                    col_n = col + 1'b1;
                    if (col == 4'd15) begin
                        state_n = half ? FIN : PAGE;
                        half_n  = 1'b1;
                    end
                end
            endcase
        end
    end
    // pixel (r,c) sits at bit 255-16r-c, i.e. the bitwise complement of {r,c}
    always_comb begin
        pix = '0;
        for (int k = 0; k < 8; k++) pix[k] = m[~{half, 3'(k), col}];
    end
    assign lcd_rw     = 1'b0;
    assign lcd_en     = busy && tcnt != '0 && tcnt <= TW'(EN_HIGH);
    assign lcd_rs     = busy && state == DATA;
    assign lcd_cs     = !busy ? 2'b00 : (state == INIT_ON || state == INIT_LINE) ? 2'b11 : s[2] ? 2'b10 : 2'b01;
    assign lcd_data   = !busy              ? 8'h00 :
                        state == INIT_ON   ? 8'h3F :
                        state == INIT_LINE ? 8'hC0 :
                        state == PAGE      ? (8'hB8 | {5'b0, l, half}) :
                        state == YADDR     ? {2'b01, s[1:0], 4'b0000} : pix;
    assign host.ready = run && state == IDLE;
    assign host.done  = state == FIN;
endmodule

// File: doc/lcd_glyph_writer.md
# lcd_glyph_writer

Downstream stage of the font decoder. Accepts one 256-bit 16×16 glyph bitmap (`mark`) plus a screen position, and writes it into a KS0108-style dual-controller 128×64 graphic LCD over its parallel bus. It runs the panel power-up sequence after reset, then services one glyph per `start`/`done` handshake. `clk` is the already-divided LCD-rate clock.

## Interface
- `EN_HIGH`, default 2: cycles `lcd_en` is held high per bus write (≥1).
- `EN_LOW`, default 2: cycles `lcd_en` is held low after the falling edge, before the next write (≥1).
- `clk` input 1: LCD-rate clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request one glyph write; accepted only when `ready`=1.
- `mark` input 256: glyph bitmap; pixel (row r, col c), r,c∈0..15, is `mark[255-16*r-c]`; 1 = pixel on.
- `slot` input 3: horizontal cell 0–7 (16 columns each); `slot[2]` selects chip.
- `line` input 2: vertical cell 0–3 (two LCD pages each).
- `ready` output 1: idle and able to accept `start`.
- `done` output 1: one-cycle pulse when a glyph write completes.
- `lcd_cs` output 2: chip selects, active-high; bit0 = left chip (cols 0–63), bit1 = right chip.
- `lcd_rs` output 1: 0 = command, 1 = data.
- `lcd_rw` output 1: constant 0 (write-only).
- `lcd_en` output 1: bus strobe; panel latches on falling edge.
- `lcd_data` output 8: bus data.

## Operation
- Bus write primitive (W = 1+EN_HIGH+EN_LOW cycles): SETUP 1 cycle (cs/rs/data driven, en=0) → EN_HI EN_HIGH cycles (en=1) → EN_LO EN_LOW cycles (en=0, cs/rs/data held). cs/rs/data change only in SETUP.
- FSM: INIT_ON → INIT_LINE → IDLE → PAGE → YADDR → DATA → (PAGE for half 1 | FIN) → IDLE.
- INIT_ON: command 0x3F (display on), `lcd_cs`=2'b11. INIT_LINE: command 0xC0 (start line 0), `lcd_cs`=2'b11.
- IDLE: `ready`=1, `lcd_cs`=2'b00, `lcd_en`=0. On `start`, latch `mark`, `slot`, `line`; `ready` drops next cycle.
- Per glyph, half h=0 then h=1:
  - PAGE: command 0xB8 | (2*line+h).
  - YADDR: command 0x40 | {slot[1:0],4'b0000}.
  - DATA: 16 data writes, c=0..15. Byte bit k (D0 = top) = pixel (8h+k, c).
- `lcd_cs` throughout a glyph = `slot[2]` ? 2'b10 : 2'b01 (latched value).
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Glyph total: 36 writes. Panel Y auto-increment is relied on; the 16 columns never cross a chip boundary.
- `start` while `ready`=0 is ignored; no queuing. Input changes after acceptance have no effect.
- `rst` at any point (mid-init, mid-glyph, mid-strobe) forces reset values next edge and restarts at INIT_ON; the partial glyph is abandoned.

## Timing
- Reset values: `ready`=0, `done`=0, `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_cs`=2'b00, `lcd_data`=8'h00; state INIT_ON.
- First SETUP of the init sequence is in the first cycle after `rst` deasserts. `ready` rises 2W cycles later (10 with defaults).
- `start` sampled in cycle t with `ready`=1 → first SETUP (page command) at t+1. `done` pulses at t+1+36W (t+181 with defaults). `ready`=1 in the cycle after `done`.
- Back-to-back: `start` held high re-triggers at the first `ready` cycle.
- `lcd_en` high width is exactly EN_HIGH cycles. Low time between strobes is ≥EN_LOW+1 cycles.

## Test plan
- Reset release → exactly two strobes: (rs=0, data 0x3F, cs 11) then (0xC0, cs 11). Each en-high is 2 cycles. `ready`=1 at cycle 10. All reset values hold while `rst`=1.
- `mark`=only bit 255 set, slot 0, line 0, `start` → cs=01; sequence 0xB8, 0x40, data 0x01 then 15×0x00; 0xB9, 0x40, 16×0x00. `done` exactly 181 cycles after `start`.
- `mark`=all ones, slot 5, line 2 → cs=10; commands 0xBC, 0x50, 16×0xFF, 0xBD, 0x50, 16×0xFF.
- `mark` row 15 only (`mark[15:0]`=16'hFFFF), slot 3, line 3 → page 0xBE data all 0x00; page 0xBF data all 0x80; Y command 0x70.
- `start` pulsed mid-glyph and `mark` changed mid-glyph → ignored. The output bytes match the latched glyph. Exactly one `done` is produced.
- `rst` asserted during an EN_HI of a DATA write → next cycle `lcd_en`=0, cs=00, `ready`=0, no `done`. After release, the init sequence repeats and a new glyph completes correctly.
